// File: rtl/aes128_key_expand_seq_if.sv
// Round-key handshake bundle between the key register, the key scheduler and AddRoundKey.
// master drives start/key_in/rk_ready; slave (the scheduler) returns the round-key stream.
interface aes128_key_expand_seq_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         done;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_idx, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_idx, done
  );
endinterface

// File: rtl/aes128_key_expand_seq.sv
// Byte-serial AES-128 key schedule: one shared S-box does SubWord over four cycles,
// then all four words of the next round key are produced in a single MIX cycle.
//
// state | meaning
// IDLE  | waiting for start; key register holds the last schedule
// EMIT  | round key rk_idx presented, waiting for rk_ready
// SUB   | SubWord(RotWord(w3)) one byte per cycle into temp
// MIX   | fold temp/rcon into w0..w3, advance rk_idx and rcon
module aes128_key_expand_seq #(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  aes128_key_expand_seq_if.slave  bus
);

  generate
    if (NR != 10) begin : g_bad_nr
      $error("aes128_key_expand_seq: NR must be 10 for AES-128");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EMIT, SUB, MIX} state_t;

  localparam logic [127:0] SBOX_ROW [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [127:0] row;
    row = SBOX_ROW[x[7:4]];
    // column 0 sits in the top byte of each row constant
    return row[{~x[3:0], 3'b000} +: 8];
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [31:0]  temp_q, temp_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   idx_q, idx_d;
  logic         rk_valid_q, rk_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  mix_t, w0_n, w1_n, w2_n, w3_n;
  logic [7:0]   sbox_in, sbox_out;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // RotWord folded into the byte select: byte k of RotWord(w3)
  always_comb begin
    sbox_in = w3[31:24];
    case (cnt_q)
      2'd0: sbox_in = w3[23:16];
      2'd1: sbox_in = w3[15:8];
      2'd2: sbox_in = w3[7:0];
      2'd3: sbox_in = w3[31:24];
      default: sbox_in = w3[31:24];
    endcase
  end

  assign sbox_out = sbox(sbox_in);

  assign mix_t = temp_q ^ {rcon_q, 24'h000000};
  assign w0_n  = w0 ^ mix_t;
  assign w1_n  = w1 ^ w0_n;
  assign w2_n  = w2 ^ w1_n;
  assign w3_n  = w3 ^ w2_n;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    temp_d     = temp_q;
    cnt_d      = cnt_q;
    rcon_d     = rcon_q;
    idx_d      = idx_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          key_d      = bus.key_in;
          idx_d      = 4'd0;
          rcon_d     = 8'h01;
          rk_valid_d = 1'b1;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (bus.rk_ready) begin
          rk_valid_d = 1'b0;
          if (idx_q == 4'(NR)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = 2'd0;
            state_d = SUB;
          end
        end
      end
      SUB: begin
        case (cnt_q)
          2'd0: temp_d[31:24] = sbox_out;
          2'd1: temp_d[23:16] = sbox_out;
          2'd2: temp_d[15:8]  = sbox_out;
          2'd3: temp_d[7:0]   = sbox_out;
          default: temp_d = temp_q;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = MIX;
      end
      MIX: begin
        key_d      = {w0_n, w1_n, w2_n, w3_n};
        idx_d      = idx_q + 4'd1;
        rcon_d     = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        rk_valid_d = 1'b1;
        state_d    = EMIT;
      end
      default: begin
        rk_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      key_q      <= '0;
      temp_q     <= '0;
      cnt_q      <= '0;
      rcon_q     <= 8'h01;
      idx_q      <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      temp_q     <= temp_d;
      cnt_q      <= cnt_d;
      rcon_q     <= rcon_d;
      idx_q      <= idx_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_out   = key_q;
  assign bus.rk_idx   = idx_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes128_key_expand_seq.sv
// Bench for aes128_key_expand_seq: directed FIPS-197 vectors, backpressure, abort-by-reset
// and randomized keys/ready, all against a word-level key-schedule model with an algebraic S-box.
module tb_aes128_key_expand_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes128_key_expand_seq_if bus();

  aes128_key_expand_seq #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] ref_rk [11];
  logic [127:0] got_rk [11];
  int           hs_edge [11];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv, xb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]}
            ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // mode 0: ready high, 1: random ready, 2: 20-cycle stall at idx 3
  task automatic run_exp(input logic [127:0] key, input int mode, input bit disturb, input int abort_hs);
    int hs = 0;
    int cyc = 0;
    int dcnt = 0;
    int bp = 0;
    logic [127:0] held_rk;
    logic [3:0]   held_idx;
    bit aborted = 1'b0;
    held_rk = '0;
    held_idx = '0;
    model(key);
    bus.key_in   = key;
    bus.start    = 1'b1;
    bus.rk_ready = 1'b0;
    step();
    bus.start = 1'b0;
    check("valid_after_start", 128'(bus.rk_valid), 128'(1));
    check("idx0_after_start", 128'(bus.rk_idx), 128'(0));
    check("done_one_cycle", 128'(bus.done), 128'(0));
    check("busy_after_start", 128'(bus.busy), 128'(1));
    while (hs < 11 && cyc < 3000 && !aborted) begin
      if (disturb && cyc == 8) begin
        bus.start  = 1'b1;
        bus.key_in = ~key;
      end else if (disturb && cyc == 9) begin
        bus.start = 1'b0;
      end
      case (mode)
        1: bus.rk_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (bus.rk_valid && bus.rk_idx == 4'd3 && bp < 20) begin
            if (bp == 0) begin
              held_rk  = bus.rk_out;
              held_idx = bus.rk_idx;
            end else begin
              check("stall_rk_stable", bus.rk_out, held_rk);
              check("stall_idx_stable", 128'(bus.rk_idx), 128'(held_idx));
              check("stall_valid_high", 128'(bus.rk_valid), 128'(1));
            end
            bus.rk_ready = 1'b0;
            bp++;
          end else begin
            bus.rk_ready = 1'b1;
          end
        end
        default: bus.rk_ready = 1'b1;
      endcase
      if (bus.rk_valid && bus.rk_ready) begin
        got_rk[hs] = bus.rk_out;
        check("rk_out", bus.rk_out, ref_rk[hs]);
        check("rk_idx", 128'(bus.rk_idx), 128'(hs));
        hs_edge[hs] = cyc + 1;
        hs++;
      end
      step();
      cyc++;
      if (bus.done) dcnt++;
      if (hs < 11) check("busy_mid", 128'(bus.busy), 128'(1));
      if (abort_hs > 0 && hs == abort_hs) begin
        step();
        #2 rst = 1'b1;
        #1;
        check("abort_valid", 128'(bus.rk_valid), 128'(0));
        check("abort_busy", 128'(bus.busy), 128'(0));
        check("abort_done", 128'(bus.done), 128'(0));
        check("abort_rk_out", bus.rk_out, 128'(0));
        check("abort_rk_idx", 128'(bus.rk_idx), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("idle_after_abort", 128'(bus.busy), 128'(0));
        aborted = 1'b1;
      end
    end
    if (!aborted) begin
      check("handshake_count", 128'(hs), 128'(11));
      check("done_pulse", 128'(bus.done), 128'(1));
      check("busy_in_done", 128'(bus.busy), 128'(0));
      check("done_count", 128'(dcnt), 128'(1));
      if (mode == 0 && hs == 11) begin
        for (int k = 0; k < 11; k++)
          check($sformatf("hs_edge_%0d", k), 128'(hs_edge[k]), 128'(1 + 6*k));
        check("done_edge", 128'(cyc + 1), 128'(62));
      end
    end
  endtask

  initial begin
    build_sbox();
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;
    step();
    step();
    check("rst_valid", 128'(bus.rk_valid), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_done", 128'(bus.done), 128'(0));
    check("rst_rk_out", bus.rk_out, 128'(0));
    check("rst_rk_idx", 128'(bus.rk_idx), 128'(0));
    rst = 1'b0;
    step();

    run_exp(FIPS_KEY, 0, 1'b0, 0);
    check("fips_rk0", got_rk[0], FIPS_KEY);
    check("fips_rk1", got_rk[1], FIPS_RK1);
    check("fips_rk10", got_rk[10], FIPS_RK10);

    // started in the done cycle of the previous run
    run_exp(128'h0, 0, 1'b0, 0);
    check("zero_rk1", got_rk[1], ZERO_RK1);
    check("zero_rk10", got_rk[10], ZERO_RK10);

    run_exp(FIPS_KEY, 2, 1'b1, 0);
    check("stall_fips_rk10", got_rk[10], FIPS_RK10);

    run_exp({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 5);
    run_exp(FIPS_KEY, 0, 1'b0, 0);
    check("post_abort_rk0", got_rk[0], FIPS_KEY);
    check("post_abort_rk10", got_rk[10], FIPS_RK10);

    for (int n = 0; n < 50; n++) begin
      run_exp({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 0);
      if (($urandom_range(0, 1)) != 0) step();
    end

    step();
    check("final_idle", 128'(bus.busy), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
